// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes SPI register-access frames from spi_slave bytes and owns the register bank.
module spi_reg_ctrl #(
    parameter int          ADDR_W  = 3,
    parameter logic [7:0]  RST_VAL = 8'h00,
    parameter logic [7:0]  RD_ERR  = 8'hEE
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_spi_cs,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_done,
    input  logic                     i_tx_done,
    output logic [7:0]               o_tx_data,
    input  logic                     i_loc_we,
    input  logic [ADDR_W-1:0]        i_loc_addr,
    input  logic [7:0]               i_loc_wdata,
    output logic [(8<<ADDR_W)-1:0]   o_regs,
    output logic                     o_wr_strb,
    output logic [ADDR_W-1:0]        o_wr_addr,
    output logic                     o_loc_coll,
    output logic                     o_busy,
    output logic                     o_err
);
    localparam int NREG = 1 << ADDR_W;
    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
    state_t                 state_q, state_d;
    logic [NREG-1:0][7:0]   regs_q, regs_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d, wr_addr_q;
    logic                   oor_q, oor_d, err_q, err_d;
    logic [7:0]             tx_q, tx_d;
    logic                   s0_q, s1_q, p_q, armed_q, wr_strb_q, coll_q;
    logic [1:0]             v_q;
    logic                   start, stop, spi_we, coll;
    // armed_q only rises once the synchronizer holds a genuinely sampled high CS, so a
    // CS already low when reset releases cannot fake a frame start
    assign start  = armed_q & p_q & ~s1_q;
    assign stop   = ~p_q & s1_q;
    assign spi_we = (state_q == WRITE) && i_rx_done && !oor_q;
    assign coll   = spi_we && i_loc_we && (i_loc_addr == ptr_q);
    assign tx_d   = (state_q == READ) ? (oor_q ? RD_ERR : regs_q[ptr_q]) : 8'h00;
    always_comb begin
        regs_d = regs_q;
        if (i_loc_we && !coll) regs_d[i_loc_addr] = i_loc_wdata;
        if (spi_we) regs_d[ptr_q] = i_rx_data;
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        oor_d   = oor_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                state_d = start ? CMD : IDLE;
                err_d   = start ? 1'b0 : err_q;
            end
            CMD: if (i_rx_done) begin
                ptr_d   = i_rx_data[ADDR_W-1:0];
                oor_d   = |i_rx_data[6:ADDR_W];
                err_d   = err_q | (|i_rx_data[6:ADDR_W]);
                state_d = i_rx_data[7] ? READ : WRITE;
            end
            WRITE: ptr_d = i_rx_done ? ptr_q + 1'b1 : ptr_q;
            READ:  ptr_d = i_tx_done ? ptr_q + 1'b1 : ptr_q;
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            p_q       <= 1'b1;
            v_q       <= '0;
            armed_q   <= 1'b0;
            state_q   <= IDLE;
            regs_q    <= {NREG{RST_VAL}};
            ptr_q     <= '0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            tx_q      <= 8'h00;
            wr_strb_q <= 1'b0;
            wr_addr_q <= '0;
            coll_q    <= 1'b0;
        end else begin
            s0_q      <= i_spi_cs;
            s1_q      <= s0_q;
            p_q       <= s1_q;
            v_q       <= {v_q[0], 1'b1};
            armed_q   <= armed_q | (v_q[1] & s1_q);
            state_q   <= state_d;
            regs_q    <= regs_d;
            ptr_q     <= ptr_d;
            oor_q     <= oor_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
            wr_strb_q <= spi_we;
            wr_addr_q <= spi_we ? ptr_q : wr_addr_q;
            coll_q    <= coll;
        end
    end
    assign o_tx_data  = tx_q;
    assign o_regs     = regs_q;
    assign o_wr_strb  = wr_strb_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_loc_coll = coll_q;
    assign o_busy     = state_q != IDLE;
    assign o_err      = err_q;
endmodule
